// File: rtl/scan3_8_pkg.sv
// Shared types and constants for the 8-channel scan controller.
// Channel count, select width and the scan FSM state encoding.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DWELL
    } state_t;

endpackage

// File: rtl/scan3_8_next_ch8.sv
// Rotated priority search: first set mask bit after cur, wrapping, cur itself last.
// With cur=7 this yields the lowest set bit, which the top uses as the scan start.
module next_ch8
    import scan_pkg::*;
(
    input  logic [CH_W-1:0]   cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   nxt,
    output logic              wrap,
    output logic              any
);

    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        // offset NUM_CH truncates to zero, so cur is tested last
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur + CH_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        any  = |mask;
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/scan3_8.sv
// Round-robin channel scan with per-channel dwell and blanking, driving a 3-to-8 decoder.
// All outputs are registered; en low or an empty mask returns the scan to IDLE.
module scan3_8
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CH_W-1:0]    sel,
    output logic               blank,
    output logic               frame_done
);

    localparam int BCNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t             state, state_nx;
    logic [CH_W-1:0]    sel_nx;
    logic               blank_nx, frame_done_nx, launch;
    logic [BCNT_W-1:0]  blank_cnt, blank_cnt_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx, dwell_load;
    logic [CH_W-1:0]    search_cur, nxt;
    logic               wrap, any;

    // From IDLE the search starts at 7 so the lowest enabled channel wins
    assign search_cur = (state == S_IDLE) ? CH_W'(NUM_CH - 1) : sel;
    assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    next_ch8 u_next (
        .cur  (search_cur),
        .mask (mask),
        .nxt  (nxt),
        .wrap (wrap),
        .any  (any)
    );

    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        blank_nx      = blank;
        frame_done_nx = 1'b0;
        blank_cnt_nx  = blank_cnt;
        dwell_cnt_nx  = dwell_cnt;
        launch        = 1'b0;

        if (!en || !any) begin
            state_nx = S_IDLE;
            blank_nx = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sel_nx = nxt;
                    launch = 1'b1;
                end
                S_BLANK: begin
                    if (blank_cnt == '0) begin
                        state_nx     = S_DWELL;
                        blank_nx     = 1'b0;
                        dwell_cnt_nx = dwell_load;
                    end else begin
                        blank_cnt_nx = blank_cnt - BCNT_W'(1);
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt == '0) begin
                        sel_nx        = nxt;
                        frame_done_nx = wrap;
                        launch        = 1'b1;
                    end else begin
                        dwell_cnt_nx = dwell_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    blank_nx = 1'b1;
                end
            endcase
        end

        // Channel start: blanking first, or straight into dwell when there is none
        if (launch) begin
            if (BLANK_CYC > 0) begin
                state_nx     = S_BLANK;
                blank_nx     = 1'b1;
                blank_cnt_nx = BLANK_LAST;
            end else begin
                state_nx     = S_DWELL;
                blank_nx     = 1'b0;
                dwell_cnt_nx = dwell_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            blank_cnt  <= '0;
            dwell_cnt  <= '0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            blank      <= blank_nx;
            frame_done <= frame_done_nx;
            blank_cnt  <= blank_cnt_nx;
            dwell_cnt  <= dwell_cnt_nx;
        end
    end

endmodule

// File: tb/tb_scan3_8.sv
// Directed bench for scan3_8 with BLANK_CYC=2: scan order, blank timing, frame_done,
// dwell sampling, en/mask drop, restart and asynchronous reset.
module tb_scan3_8;

    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  mask = 8'h00;
    logic [15:0] dwell = 16'd0;
    logic [2:0]  sel;
    logic        blank;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    scan3_8 #(.DWELL_W(16), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int s, input int b, input int f);
        chk({tag, ".sel"}, int'(sel), s);
        chk({tag, ".blank"}, int'(blank), b);
        chk({tag, ".frame_done"}, int'(frame_done), f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles c0..c1-1 of a channel period: BC blank cycles, then unblanked dwell
    task automatic chan(input string tag, input int s, input bit fd0, input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            tick();
            chk_out($sformatf("%s.ch%0d.c%0d", tag, s, c), s, (c < BC) ? 1 : 0,
                    (fd0 && c == 0) ? 1 : 0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_out("reset", 0, 1, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk_out("idle_en0", 0, 1, 0);

        // Full mask, dwell 3: 0..7 then wrap to 0 with frame_done
        mask  = 8'hFF;
        dwell = 16'd3;
        en    = 1'b1;
        for (int ch = 0; ch <= 8; ch++)
            chan("ff", ch % 8, ch == 8, 0, 5);

        // en dropped at first dwell cycle of channel 1
        chan("ff", 1, 1'b0, 0, 3);
        en = 1'b0;
        tick();
        chk_out("en_drop", 1, 1, 0);
        tick();
        chk_out("en_drop_hold", 1, 1, 0);

        // Re-enable restarts at lowest channel with full blanking
        en = 1'b1;
        chan("reen", 0, 1'b0, 0, 5);
        chan("reen", 1, 1'b0, 0, 5);

        // Sparse mask applied at channel change
        mask = 8'b1010_0100;
        chan("sparse", 2, 1'b0, 0, 5);
        chan("sparse", 5, 1'b0, 0, 5);
        chan("sparse", 7, 1'b0, 0, 5);
        chan("sparse", 2, 1'b1, 0, 5);
        chan("sparse", 5, 1'b0, 0, 5);
        chan("sparse", 7, 1'b0, 0, 5);

        // Single channel: every change is a wrap
        mask = 8'h10;
        chan("single", 4, 1'b1, 0, 5);
        chan("single", 4, 1'b1, 0, 5);
        chan("single", 4, 1'b1, 0, 5);

        // dwell=0 behaves as one cycle
        dwell = 16'd0;
        chan("dw0", 4, 1'b1, 0, 3);
        chan("dw0", 4, 1'b1, 0, 3);

        // Mid-dwell change only affects the next channel
        dwell = 16'd3;
        chan("dwchg", 4, 1'b1, 0, 3);
        dwell = 16'd0;
        chan("dwchg", 4, 1'b1, 3, 5);
        chan("dwchg_next", 4, 1'b1, 0, 3);

        // mask cleared mid-dwell, then a new mask restarts at its lowest bit
        dwell = 16'd3;
        chan("mask0", 4, 1'b1, 0, 3);
        mask = 8'h00;
        tick();
        chk_out("mask0_drop", 4, 1, 0);
        mask = 8'b0110_0000;
        chan("remask", 5, 1'b0, 0, 5);
        chan("remask", 6, 1'b0, 0, 5);
        chan("remask", 5, 1'b1, 0, 5);
        chan("remask", 6, 1'b0, 0, 3);

        // Asynchronous reset between edges while in DWELL
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 1, 0);
        tick();
        chk_out("async_rst_hold", 0, 1, 0);
        #3 rst_n = 1'b1;
        #1 chk_out("rst_release", 0, 1, 0);
        chan("post_rst", 5, 1'b0, 0, 5);
        chan("post_rst", 6, 1'b0, 0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
